alu_operand_sequencer: RTL and testbench

Upstream operand-capture stage for the 7-bit board ALU. It takes the shared 7-bit switch bus plus two push keys and sequences them into registered, stable A/B operands and a registered opcode. These feed the combinational ALU directly, so the ALU never latches operands through feedback. A one-cycle `op_valid` strobe marks every new operand/opcode set.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/key_conditioner.sv | 76 +++++++
 rtl/alu_operand_sequencer.sv | 117 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the board ALU front end: operand width, opcode
// names and the operand-sequencer FSM state encoding.
package alu_pkg;

  localparam int ALU_W = 7;
  localparam int OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_EQ  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RUN = 2'd2,
    S_BAD = 2'd3
  } seq_state_t;

endpackage

// File: rtl/key_conditioner.sv
// Turns a raw asynchronous push key into a single-cycle press pulse:
// 2-flop synchronizer, optional debounce (ALU_SEQ_DEBOUNCE_EN), rising-edge detect.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  localparam bit DEBOUNCE_EN =
`ifdef ALU_SEQ_DEBOUNCE_EN
    1'b1;
`else
    1'b0;
`endif

  logic sync1_reg;
  logic sync2_reg;
  logic level;
  logic level_d_reg;
  logic pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    if (DEBOUNCE_EN && (DEBOUNCE_CYCLES > 0) && (CNT_W > 0)) begin : g_debounce
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;

      // sync1 != sync2 means the synchronized level is about to change,
      // so the stability count restarts.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (sync1_reg != sync2_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_MAX - 1'b1) begin
            filt_reg <= sync2_reg;
          end
        end
      end

      assign level = filt_reg;
    end else begin : g_raw
      assign level = sync2_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      level_d_reg <= level;
      pulse_reg   <= level & ~level_d_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Sequences the shared switch bus into registered A/B operands and opcode
// for the combinational ALU. Debounce enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ALU_W-1:0] t,
  input  logic [OP_W-1:0]  choose_in,
  input  logic             key_load,
  input  logic             key_clear,
  output logic [ALU_W-1:0] a,
  output logic [ALU_W-1:0] b,
  output logic [OP_W-1:0]  choose,
  output logic             op_valid,
  output logic [1:0]       state
);

  logic [1:0] key_raw;
  logic [1:0] key_p;
  logic       load_p;
  logic       clear_p;

  assign key_raw = {key_clear, key_load};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_key (
        .clk  (clk),
        .rst  (rst),
        .key  (key_raw[gi]),
        .pulse(key_p[gi])
      );
    end
  endgenerate

  assign load_p  = key_p[0];
  assign clear_p = key_p[1];

  seq_state_t       state_reg, state_next;
  logic [ALU_W-1:0] a_reg, a_next;
  logic [ALU_W-1:0] b_reg, b_next;
  logic [OP_W-1:0]  choose_reg, choose_next;
  logic             op_valid_reg, op_valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_A;
      a_reg        <= '0;
      b_reg        <= '0;
      choose_reg   <= '0;
      op_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      choose_reg   <= choose_next;
      op_valid_reg <= op_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    choose_next   = choose_reg;
    op_valid_next = 1'b0;
    if (clear_p) begin
      state_next  = S_A;
      a_next      = '0;
      b_next      = '0;
      choose_next = '0;
    end else begin
      case (state_reg)
        S_A: begin
          if (load_p) begin
            a_next     = t;
            state_next = S_B;
          end
        end
        S_B: begin
          if (load_p) begin
            b_next        = t;
            choose_next   = choose_in;
            op_valid_next = 1'b1;
            state_next    = S_RUN;
          end
        end
        S_RUN: begin
          choose_next = choose_in;
          // A new load starts a fresh pair, so it suppresses the opcode strobe.
          if (load_p) begin
            a_next     = t;
            b_next     = '0;
            state_next = S_B;
          end else if (choose_in != choose_reg) begin
            op_valid_next = 1'b1;
          end
        end
        default: state_next = S_A;
      endcase
    end
  end

  assign a        = a_reg;
  assign b        = b_reg;
  assign choose   = choose_reg;
  assign op_valid = op_valid_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized self-checking bench for alu_operand_sequencer against a
// cycle-level behavioural model plus directed literal checks.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int DB   = 4;
  localparam int LAT  = DB + 3;
  localparam int HOLD = DB + 2;
`else
  localparam int DB   = 4;
  localparam int LAT  = 3;
  localparam int HOLD = 1;
`endif
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] t;
  logic [2:0] choose_in;
  logic       key_load;
  logic       key_clear;
  logic [6:0] a;
  logic [6:0] b;
  logic [2:0] choose;
  logic       op_valid;
  logic [1:0] state;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t        (t),
    .choose_in(choose_in),
    .key_load (key_load),
    .key_clear(key_clear),
    .a        (a),
    .b        (b),
    .choose   (choose),
    .op_valid (op_valid),
    .state    (state)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rst = 0;
  int ov_count = 0;
  bit model_en = 1'b0;

  logic kl_h[MAXC];
  logic kc_h[MAXC];

  logic [6:0] m_a, m_b;
  logic [2:0] m_ch;
  logic       m_ov;
  logic [1:0] m_st;

  // A key press becomes a pulse LAT edges after its first sampled high level;
  // anything sampled at or before the latest reset edge is forgotten.
  function automatic bit rose_at(input bit is_clear, input int k);
    logic c, p;
    if (k <= last_rst || k < 1) return 1'b0;
    c = is_clear ? kc_h[k] : kl_h[k];
    p = (k - 1 <= last_rst) ? 1'b0 : (is_clear ? kc_h[k-1] : kl_h[k-1]);
    return c & ~p;
  endfunction

  task automatic model_step(input bit lp, input bit cp);
    m_ov = 1'b0;
    if (cp) begin
      m_a = '0; m_b = '0; m_ch = '0; m_st = 2'd0;
    end else if (m_st == 2'd3) begin
      m_st = 2'd0;
    end else if (m_st == 2'd0) begin
      if (lp) begin m_a = t; m_st = 2'd1; end
    end else if (m_st == 2'd1) begin
      if (lp) begin m_b = t; m_ch = choose_in; m_ov = 1'b1; m_st = 2'd2; end
    end else begin
      if (lp) begin
        m_a = t; m_b = '0; m_st = 2'd1;
      end else if (choose_in != m_ch) begin
        m_ov = 1'b1;
      end
      m_ch = choose_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget used=%0d limit=%0d", cyc, MAXC);
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
    end
    kl_h[cyc] = key_load;
    kc_h[cyc] = key_clear;
    if (rst) begin
      last_rst = cyc;
      m_a = '0; m_b = '0; m_ch = '0; m_ov = 1'b0; m_st = 2'd0;
    end else begin
      model_step(rose_at(1'b0, cyc - LAT), rose_at(1'b1, cyc - LAT));
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      tests++;
      if ({a, b, choose, op_valid, state} !== {m_a, m_b, m_ch, m_ov, m_st}) begin
        fails++;
        $display("FAIL outputs cyc=%0d got a=%0d b=%0d ch=%0d ov=%0b st=%0d required a=%0d b=%0d ch=%0d ov=%0b st=%0d",
                 cyc, a, b, choose, op_valid, state, m_a, m_b, m_ch, m_ov, m_st);
      end
      if (op_valid === 1'b1) ov_count++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic rand_inputs();
    t = 7'($urandom);
    if ($urandom_range(3) == 0) choose_in = 3'($urandom);
  endtask

  task automatic press(input bit ld, input bit clr, input int hold, input int gap, input bit rnd);
    key_load  = ld;
    key_clear = clr;
    repeat (hold) begin
      if (rnd) rand_inputs();
      tick();
    end
    key_load  = 1'b0;
    key_clear = 1'b0;
    repeat (gap) begin
      if (rnd) rand_inputs();
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; t = '0; choose_in = '0; key_load = 1'b0; key_clear = 1'b0;
    tick();
    model_en = 1'b1;
    tick(); tick();
    check("reset_a", int'(a), 0);
    check("reset_state", int'(state), 0);
    check("reset_op_valid", int'(op_valid), 0);
    rst = 1'b0;
    repeat (HOLD + 3) tick();

    // Two loads form the first operand set.
    ov_count = 0;
    t = 7'd12; press(1'b1, 1'b0, HOLD, LAT + 2, 1'b0);
    check("load_a_state", int'(state), 1);
    t = 7'd5;  press(1'b1, 1'b0, HOLD, LAT + 2, 1'b0);
    check("pair_a", int'(a), 12);
    check("pair_b", int'(b), 5);
    check("pair_choose", int'(choose), 0);
    check("pair_state", int'(state), 2);
    check("pair_ov_count", ov_count, 1);

    // Opcode change in S_RUN re-strobes once.
    ov_count = 0;
    choose_in = 3'd3;
    tick(); tick();
    check("opchg_choose", int'(choose), 3);
    repeat (5) tick();
    check("opchg_ov_count", ov_count, 1);

    // Reload from S_RUN, then simultaneous clear+load in S_B.
    t = 7'd77; press(1'b1, 1'b0, HOLD, LAT + 2, 1'b0);
    check("reload_a", int'(a), 77);
    check("reload_b", int'(b), 0);
    check("reload_state", int'(state), 1);
    ov_count = 0;
    press(1'b1, 1'b1, HOLD, LAT + 2, 1'b0);
    check("clrwin_state", int'(state), 0);
    check("clrwin_a", int'(a), 0);
    check("clrwin_b", int'(b), 0);
    check("clrwin_ov_count", ov_count, 0);

    // Reset in S_B with a = 100.
    t = 7'd100; press(1'b1, 1'b0, HOLD, LAT + 2, 1'b0);
    check("pre_rst_a", int'(a), 100);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_choose", int'(choose), 0);
    check("rst_op_valid", int'(op_valid), 0);
    check("rst_state", int'(state), 0);
    t = 7'd33; press(1'b1, 1'b0, HOLD, LAT + 2, 1'b0);
    check("post_rst_a", int'(a), 33);
    check("post_rst_state", int'(state), 1);

    // Reset during an in-flight press discards it.
    key_load = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    key_load = 1'b0;
    repeat (LAT + 4) tick();
    check("inflight_state", int'(state), 0);
    check("inflight_a", int'(a), 0);

    // Illegal state recovers to S_A with outputs held.
    t = 7'd33; press(1'b1, 1'b0, HOLD, LAT + 2, 1'b0);
    #1 force dut.state_reg = S_BAD;
    #1 release dut.state_reg;
    m_st = 2'd3;
    check("forced_state", int'(state), 3);
    tick();
    check("illegal_state", int'(state), 0);
    check("illegal_a", int'(a), 33);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(9))
        0, 1, 2, 3, 4: press(1'b1, 1'b0, HOLD + int'($urandom_range(3)), LAT + 1 + int'($urandom_range(3)), 1'b1);
        5:             press(1'b0, 1'b1, HOLD + int'($urandom_range(3)), LAT + 1 + int'($urandom_range(3)), 1'b1);
        6:             press(1'b1, 1'b1, HOLD, LAT + 1, 1'b1);
        7: begin
          rst = 1'b1; rand_inputs(); tick(); rst = 1'b0;
        end
        default: begin
          repeat (1 + $urandom_range(3)) begin
            rand_inputs();
            tick();
          end
        end
      endcase
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    // Bouncing key: only the final stable level is accepted.
    begin
      int first_seen;
      model_en = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (DB + 4) tick();
      key_load = 1'b1; tick();
      key_load = 1'b0; tick();
      key_load = 1'b1; tick();
      key_load = 1'b0; tick();
      key_load = 1'b1; tick();
      first_seen = -1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (state != 2'd0 && first_seen < 0) first_seen = i;
      end
      key_load = 1'b0;
      repeat (DB + 6) tick();
      check("bounce_load_edge", first_seen, DB + 3);
      check("bounce_single_load", int'(state), 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
